// File: rtl/hwpe_dma_loader.sv
// Preloads the HWPE fmap banks and kernel SRAM from a byte-addressed source memory.
// One 64-bit read is outstanding at a time; every returned word becomes one dma write.
module hwpe_dma_loader #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned SRC_AW     = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SRC_AW-1:0]     cfg_f1_src,
    input  logic [ADDR_WIDTH-1:0] cfg_f1_dst,
    input  logic [SRC_AW-1:0]     cfg_f2_src,
    input  logic [ADDR_WIDTH-1:0] cfg_f2_dst,
    input  logic [CNT_W-1:0]      cfg_fwords,
    input  logic [SRC_AW-1:0]     cfg_k_src,
    input  logic [ADDR_WIDTH-1:0] cfg_k_dst,
    input  logic [CNT_W-1:0]      cfg_kwords,
    output logic                  src_req_valid,
    input  logic                  src_req_ready,
    output logic [SRC_AW-1:0]     src_req_addr,
    input  logic                  src_rsp_valid,
    input  logic [63:0]           src_rsp_data,
    output logic                  dma_wen,
    output logic [ADDR_WIDTH-1:0] dma_wa,
    output logic [63:0]           dma_wd,
    output logic                  busy,
    output logic                  fmap_done,
    output logic                  kernel_done,
    output logic                  done
);

    typedef enum logic [2:0] {S_IDLE, S_F1, S_F2, S_KRN, S_FIN} state_t;
    typedef enum logic [1:0] {P_REQ, P_WAIT, P_DRAIN} phase_t;

    state_t                state;
    phase_t                phase;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      fwords_q;
    logic [CNT_W-1:0]      kwords_q;
    logic [CNT_W-1:0]      seg_words;
    logic [SRC_AW-1:0]     f2_src_q;
    logic [SRC_AW-1:0]     k_src_q;
    logic [ADDR_WIDTH-1:0] f2_dst_q;
    logic [ADDR_WIDTH-1:0] k_dst_q;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic                  last_word;

    always_comb begin
        seg_words = (state == S_KRN) ? kwords_q : fwords_q;
        last_word = (cnt == seg_words - CNT_W'(1));
    end

    // src_req_addr doubles as the running source pointer of the active segment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            phase         <= P_REQ;
            cnt           <= '0;
            fwords_q      <= '0;
            kwords_q      <= '0;
            f2_src_q      <= '0;
            k_src_q       <= '0;
            f2_dst_q      <= '0;
            k_dst_q       <= '0;
            dst_ptr       <= '0;
            src_req_valid <= 1'b0;
            src_req_addr  <= '0;
            dma_wen       <= 1'b0;
            dma_wa        <= '0;
            dma_wd        <= '0;
            busy          <= 1'b0;
            fmap_done     <= 1'b0;
            kernel_done   <= 1'b0;
            done          <= 1'b0;
        end else if (abort) begin
            state         <= S_IDLE;
            phase         <= P_REQ;
            cnt           <= '0;
            src_req_valid <= 1'b0;
            dma_wen       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            dma_wen <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        fwords_q    <= cfg_fwords;
                        kwords_q    <= cfg_kwords;
                        f2_src_q    <= cfg_f2_src;
                        f2_dst_q    <= cfg_f2_dst;
                        k_src_q     <= cfg_k_src;
                        k_dst_q     <= cfg_k_dst;
                        fmap_done   <= (cfg_fwords == '0);
                        kernel_done <= (cfg_kwords == '0);
                        cnt         <= '0;
                        phase       <= P_REQ;
                        busy        <= 1'b1;
                        // empty segments are skipped without spending a cycle
                        if (cfg_fwords != '0) begin
                            state         <= S_F1;
                            src_req_addr  <= cfg_f1_src;
                            dst_ptr       <= cfg_f1_dst;
                            src_req_valid <= 1'b1;
                        end else if (cfg_kwords != '0) begin
                            state         <= S_KRN;
                            src_req_addr  <= cfg_k_src;
                            dst_ptr       <= cfg_k_dst;
                            src_req_valid <= 1'b1;
                        end else begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                S_F1, S_F2, S_KRN: begin
                    case (phase)
                        P_REQ: begin
                            if (src_req_ready) begin
                                src_req_valid <= 1'b0;
                                phase         <= P_WAIT;
                            end
                        end
                        P_WAIT: begin
                            if (src_rsp_valid) begin
                                dma_wen <= 1'b1;
                                dma_wa  <= dst_ptr;
                                dma_wd  <= src_rsp_data;
                                if (last_word) begin
                                    cnt <= '0;
                                    if (state == S_F2)  fmap_done   <= 1'b1;
                                    if (state == S_KRN) kernel_done <= 1'b1;
                                    if (state == S_F1) begin
                                        state         <= S_F2;
                                        src_req_addr  <= f2_src_q;
                                        dst_ptr       <= f2_dst_q;
                                        src_req_valid <= 1'b1;
                                        phase         <= P_REQ;
                                    end else if (state == S_F2 && kwords_q != '0) begin
                                        state         <= S_KRN;
                                        src_req_addr  <= k_src_q;
                                        dst_ptr       <= k_dst_q;
                                        src_req_valid <= 1'b1;
                                        phase         <= P_REQ;
                                    end else begin
                                        phase <= P_DRAIN;
                                    end
                                end else begin
                                    cnt           <= cnt + CNT_W'(1);
                                    src_req_addr  <= src_req_addr + SRC_AW'(8);
                                    dst_ptr       <= dst_ptr + ADDR_WIDTH'(8);
                                    src_req_valid <= 1'b1;
                                    phase         <= P_REQ;
                                end
                            end
                        end
                        P_DRAIN: begin
                            // final write is on the bus this cycle; FIN follows it
                            state <= S_FIN;
                            phase <= P_REQ;
                            done  <= 1'b1;
                        end
                        default: phase <= P_REQ;
                    endcase
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_dma_loader.sv
// Randomized bench for hwpe_dma_loader: source memory responder plus a write-list reference model.
module tb_hwpe_dma_loader;

    localparam int unsigned AW  = 16;
    localparam int unsigned SAW = 32;
    localparam int unsigned CW  = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start, abort;
    logic [SAW-1:0] cfg_f1_src, cfg_f2_src, cfg_k_src;
    logic [AW-1:0]  cfg_f1_dst, cfg_f2_dst, cfg_k_dst;
    logic [CW-1:0]  cfg_fwords, cfg_kwords;
    logic           src_req_valid, src_req_ready;
    logic [SAW-1:0] src_req_addr;
    logic           src_rsp_valid;
    logic [63:0]    src_rsp_data;
    logic           dma_wen;
    logic [AW-1:0]  dma_wa;
    logic [63:0]    dma_wd;
    logic           busy, fmap_done, kernel_done, done;

    always #5 clk = ~clk;

    hwpe_dma_loader #(.ADDR_WIDTH(AW), .SRC_AW(SAW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_f1_src(cfg_f1_src), .cfg_f1_dst(cfg_f1_dst),
        .cfg_f2_src(cfg_f2_src), .cfg_f2_dst(cfg_f2_dst), .cfg_fwords(cfg_fwords),
        .cfg_k_src(cfg_k_src), .cfg_k_dst(cfg_k_dst), .cfg_kwords(cfg_kwords),
        .src_req_valid(src_req_valid), .src_req_ready(src_req_ready),
        .src_req_addr(src_req_addr), .src_rsp_valid(src_rsp_valid),
        .src_rsp_data(src_rsp_data), .dma_wen(dma_wen), .dma_wa(dma_wa),
        .dma_wd(dma_wd), .busy(busy), .fmap_done(fmap_done),
        .kernel_done(kernel_done), .done(done)
    );

    typedef struct {
        logic [AW-1:0] wa;
        logic [63:0]   wd;
        logic          fd;
        logic          kd;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  wr_cnt = 0;
    int  last_wr_cyc = -1;
    bit  done_seen = 1'b0;
    bit  zero_wait = 1'b0;
    int  lat = 1;
    int  bp = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // source memory contents are a fixed function of the byte address
    function automatic logic [63:0] memf(input logic [SAW-1:0] a);
        return {a ^ 32'h5A5A_C3C3, ~a + 32'h0123_4567};
    endfunction

    // source responder: random-length ready stalls and fixed response latency
    bit             pend = 1'b0;
    bit             hs_q = 1'b0;
    bit             pv_q = 1'b0;
    bit             pr_q = 1'b0;
    logic [SAW-1:0] pend_addr, pa_q;
    int             wait_left = 0;
    int             stall_left = 0;

    initial begin
        src_req_ready = 1'b1;
        src_rsp_valid = 1'b0;
        src_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0; hs_q = 1'b0; pv_q = 1'b0;
                src_rsp_valid = 1'b0;
            end else begin
                if (hs_q) begin
                    check("one_outstanding", 64'(pend), 64'(0));
                    pend = 1'b1; pend_addr = pa_q; wait_left = lat - 1;
                    stall_left = bp;
                end
                if (pv_q && !pr_q && src_req_valid)
                    check("req_addr_stable", 64'(src_req_addr), 64'(pa_q));
                src_rsp_valid = 1'b0;
                if (pend) begin
                    if (wait_left == 0) begin
                        src_rsp_valid = 1'b1;
                        src_rsp_data  = memf(pend_addr);
                        pend = 1'b0;
                    end else begin
                        wait_left--;
                    end
                end
                if (stall_left != 0) begin
                    src_req_ready = 1'b0;
                    if (src_req_valid) stall_left--;
                end else begin
                    src_req_ready = 1'b1;
                end
                pv_q = src_req_valid;
                pr_q = src_req_ready;
                pa_q = src_req_addr;
                hs_q = src_req_valid && src_req_ready;
            end
        end
    end

    // write monitor against the expected write list
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && dma_wen) begin
                wr_cnt++;
                check("wen_while_busy", 64'(busy), 64'(1));
                if (exp_q.size() == 0) begin
                    check("extra_write", 64'(dma_wa), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wa", 64'(dma_wa), 64'(e.wa));
                    check("wd", dma_wd, e.wd);
                    check("fmap_done_at_wr", 64'(fmap_done), 64'(e.fd));
                    check("kernel_done_at_wr", 64'(kernel_done), 64'(e.kd));
                end
                if (zero_wait && last_wr_cyc >= 0)
                    check("wr_gap", 64'(cyc - last_wr_cyc), 64'(2));
                last_wr_cyc = cyc;
            end
            if (rst_n && done) begin
                done_seen = 1'b1;
                check("fin_busy", 64'(busy), 64'(1));
                if (last_wr_cyc >= 0)
                    check("done_lat", 64'(cyc - last_wr_cyc), 64'(1));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [SAW-1:0] f1s, input logic [AW-1:0] f1d,
                          input logic [SAW-1:0] f2s, input logic [AW-1:0] f2d,
                          input int fw,
                          input logic [SAW-1:0] ks, input logic [AW-1:0] kd,
                          input int kw);
        wr_t e;
        logic [SAW-1:0] s;
        logic [AW-1:0]  d;
        int n;
        exp_q.delete();
        for (int seg = 0; seg < 3; seg++) begin
            s = (seg == 0) ? f1s : (seg == 1) ? f2s : ks;
            d = (seg == 0) ? f1d : (seg == 1) ? f2d : kd;
            n = (seg == 2) ? kw : fw;
            for (int i = 0; i < n; i++) begin
                e.wa = d + AW'(8 * i);
                e.wd = memf(s + SAW'(8 * i));
                e.fd = (fw == 0) || (seg == 2) || (seg == 1 && i == n - 1);
                e.kd = (kw == 0) || (seg == 2 && i == n - 1);
                exp_q.push_back(e);
            end
        end
        cfg_f1_src = f1s; cfg_f1_dst = f1d; cfg_f2_src = f2s; cfg_f2_dst = f2d;
        cfg_k_src = ks; cfg_k_dst = kd;
        cfg_fwords = CW'(fw); cfg_kwords = CW'(kw);
        last_wr_cyc = -1; done_seen = 1'b0; wr_cnt = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_load();
        int t = 0;
        while (!done_seen && t < 3000) begin
            tick();
            t++;
        end
        check("done_timeout", 64'(done_seen), 64'(1));
        tick();
        check("missing_writes", 64'(exp_q.size()), 64'(0));
        check("busy_after", 64'(busy), 64'(0));
        check("fmap_done_after", 64'(fmap_done), 64'(1));
        check("kernel_done_after", 64'(kernel_done), 64'(1));
        check("done_cleared", 64'(done), 64'(0));
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wr_cnt < n && t < 2000) begin
            tick();
            t++;
        end
        check("wait_writes_timeout", 64'(wr_cnt >= n), 64'(1));
    endtask

    initial begin
        int w0, t;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_f1_src = '0; cfg_f1_dst = '0; cfg_f2_src = '0; cfg_f2_dst = '0;
        cfg_k_src = '0; cfg_k_dst = '0; cfg_fwords = '0; cfg_kwords = '0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_req_valid", 64'(src_req_valid), 64'(0));
        check("rst_wen", 64'(dma_wen), 64'(0));
        check("rst_flags", 64'({fmap_done, kernel_done, done}), 64'(0));
        rst_n = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'(0));

        // basic load, zero-wait source
        lat = 1; bp = 0; zero_wait = 1'b1;
        launch(32'h0, 16'h0, 32'h1A8, 16'h800, 3, 32'h400, 16'h1000, 2);
        finish_load();

        // backpressure: ready low 5 cycles per request, latency 4
        lat = 4; bp = 5; zero_wait = 1'b0;
        launch(32'h100, 16'h40, 32'h2000, 16'h900, 2, 32'h3008, 16'h1200, 3);
        finish_load();

        // fmap segments skipped
        lat = 2; bp = 0;
        launch(32'h10, 16'h10, 32'h20, 16'h20, 0, 32'h7770, 16'h1500, 1);
        finish_load();

        // abort after the second fmap bank 1 write, late response is dropped
        lat = 3; bp = 0;
        launch(32'h0, 16'h0, 32'h1A8, 16'h800, 3, 32'h400, 16'h1000, 2);
        wait_writes(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_req_valid", 64'(src_req_valid), 64'(0));
        check("abort_wen", 64'(dma_wen), 64'(0));
        check("abort_flags", 64'({fmap_done, kernel_done}), 64'(0));
        w0 = wr_cnt;
        repeat (10) tick();
        check("late_rsp_write", 64'(wr_cnt), 64'(w0));
        launch(32'h0, 16'h0, 32'h1A8, 16'h800, 3, 32'h400, 16'h1000, 2);
        finish_load();

        // start with new cfg while busy in KRN is ignored
        lat = 2; bp = 1;
        launch(32'h40, 16'h100, 32'h80, 16'h300, 2, 32'h600, 16'h2000, 3);
        wait_writes(5);
        cfg_k_src = 32'h9990; cfg_k_dst = 16'h4440; cfg_kwords = 16'd7;
        cfg_f1_src = 32'h1230; cfg_fwords = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_load();

        // random loads, including address wrap and all-zero counts
        repeat (6) begin
            lat = $urandom_range(1, 4);
            bp  = $urandom_range(0, 3);
            zero_wait = (lat == 1 && bp == 0);
            launch($urandom, 16'hFFF0 + AW'($urandom_range(0, 8)), $urandom,
                   AW'($urandom), $urandom_range(0, 3),
                   32'hFFFF_FFF0, AW'($urandom), $urandom_range(0, 3));
            finish_load();
        end

        // asynchronous reset while an F2 write is on the bus
        lat = 1; bp = 0; zero_wait = 1'b0;
        launch(32'h0, 16'h0, 32'h1A8, 16'h800, 3, 32'h400, 16'h1000, 2);
        t = 0;
        while (!(dma_wen && wr_cnt > 3) && t < 200) begin
            tick();
            t++;
        end
        check("f2_wen_seen", 64'(dma_wen), 64'(1));
        rst_n = 1'b0;
        #1;
        check("arst_wen", 64'(dma_wen), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_req_valid", 64'(src_req_valid), 64'(0));
        check("arst_flags", 64'({fmap_done, kernel_done, done}), 64'(0));
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 64'(busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hwpe_dma_loader.md
Name: hwpe_dma_loader

Overview:
- Sequencer that preloads the HWPE local SRAMs over the `dma_wen`/`dma_wa`/`dma_wd` write port before the EAI instruction stream starts.
- Fetches 64-bit words from a byte-addressed source memory and writes three segments in fixed order: fmap bank 1, fmap bank 2, then kernel.
- Raises per-segment done flags so the instruction issuer can start.
- Sits between the system fabric / source memory and the `hwpe` DMA write port.

Parameters:
- ADDR_WIDTH, 16, width of `dma_wa` and of the destination base addresses (matches HWPE_ADDR_WIDTH).
- SRC_AW, 32, width of source byte addresses.
- CNT_W, 16, width of the segment word counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE.
- cfg_f1_src  in  SRC_AW  fmap bank 1 source byte base.
- cfg_f1_dst  in  ADDR_WIDTH  fmap bank 1 SRAM base.
- cfg_f2_src  in  SRC_AW  fmap bank 2 source byte base.
- cfg_f2_dst  in  ADDR_WIDTH  fmap bank 2 SRAM base (FMEM_ADDR2_START).
- cfg_fwords  in  CNT_W  64-bit words per fmap bank.
- cfg_k_src  in  SRC_AW  kernel source byte base.
- cfg_k_dst  in  ADDR_WIDTH  kernel SRAM base (KMEM_ADDR_START).
- cfg_kwords  in  CNT_W  kernel 64-bit words.
- src_req_valid  out  1  source read request.
- src_req_ready  in  1  source accepts the request.
- src_req_addr  out  SRC_AW  source byte address.
- src_rsp_valid  in  1  read data valid.
- src_rsp_data  in  64  read data, byte 0 in [7:0].
- dma_wen  out  1  SRAM write enable.
- dma_wa  out  ADDR_WIDTH  SRAM byte address.
- dma_wd  out  64  SRAM write data.
- busy  out  1  high in any state other than IDLE.
- fmap_done  out  1  sticky; set when both fmap banks are written.
- kernel_done  out  1  sticky; set when the kernel segment is written.
- done  out  1  one-cycle pulse when all segments are complete.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- States:
  - IDLE: on `start`, latch all cfg inputs, clear `fmap_done` and `kernel_done`, go to F1.
  - F1 → F2 → KRN → FIN → IDLE.
  - A segment whose word count is 0 is skipped in zero cycles, e.g. F1 goes straight to KRN when `cfg_fwords`=0. Its done flag is still set.
- Per-word flow:
  - REQ sub-phase: `src_req_valid`=1 with `src_req_addr` = src_base + 8*i.
  - On valid&ready, drop `src_req_valid` and enter WAIT.
  - Exactly one request is outstanding at any time.
- Response handling:
  - `src_rsp_valid` in WAIT: the next cycle drives `dma_wen`=1, `dma_wa` = dst_base + 8*i, `dma_wd` = `src_rsp_data`.
  - In that same cycle, `src_req_valid` rises for word i+1 if one remains.
  - Peak throughput is 1 word per 2 cycles when ready is high and the response comes 1 cycle after the request.
- `src_rsp_valid` outside WAIT is ignored.
- `dma_wen` is high exactly one cycle per word and never high in IDLE or FIN.
- Segment completion:
  - The last-word write of F2 sets `fmap_done` in the same edge as the write.
  - The last-word write of KRN sets `kernel_done`.
  - FIN lasts 1 cycle and pulses `done`.
- Arithmetic:
  - Address adds wrap modulo 2^ADDR_WIDTH and 2^SRC_AW; no error is flagged.
  - The word counter compares i == count-1 at CNT_W width.
- `start` while busy is ignored; the latched configuration is unchanged.
- Abort:
  - `abort` in any state: next cycle goes to IDLE, `src_req_valid`=0, `dma_wen`=0.
  - Done flags keep their current values.
  - A response pending after abort is discarded.
  - `abort` and `start` in the same cycle: abort wins.
- Reset mid-operation: asynchronous return to IDLE with all outputs cleared immediately.

Test Plan:
- Basic load: `cfg_fwords`=3, `cfg_kwords`=2, f1 src 0x0 → dst 0x0, f2 src 0x1A8 → dst 0x800, k src 0x400 → dst 0x1000, zero-wait source → 8 writes at wa 0x0, 0x8, 0x10, 0x800, 0x808, 0x810, 0x1000, 0x1008.
  - Data must match source bytes.
  - `fmap_done` rises with the 0x810 write.
  - `done` pulses 1 cycle after the 0x1008 write; back-to-back writes are 2 cycles apart.
- Backpressure: `src_req_ready` low for 5 cycles and response latency 4 → `src_req_addr` is stable while valid, only one request is outstanding, and there are no extra or missing `dma_wen` pulses.
- Zero-count skip: `cfg_fwords`=0, `cfg_kwords`=1 → `fmap_done`=1 with no fmap writes, exactly one write at `cfg_k_dst`, then `done`.
- Abort: assert `abort` after the 2nd fmap bank 1 write → IDLE next cycle, the late `src_rsp_valid` produces no write, and a new `start` reloads from word 0.
- Start while busy: pulse `start` with changed cfg mid-KRN → ignored; the original addresses complete.
- Async reset mid-F2 with `dma_wen` high → outputs drop to 0 without waiting for `clk`, and `busy`=0.
